enemy_sprite_engine: RTL

- Parametrised multi-enemy motion and draw engine for the 160x120 VGA adapter. Successor to the fixed three-enemy path generator.
- Moves NUM_ENEMIES 1x1 sprites: horizontal bounce plus vertical fall, with respawn at a per-enemy spawn column.
- Serialises erase/draw pixel writes onto a single x/y/colour/plot stream for the VGA adapter.
- Adds an explicit plot strobe, an erase pass and per-enemy hit-driven direction reversal.

---
 rtl/enemy_sprite_engine.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/enemy_sprite_engine.sv
// Multi-enemy bounce/fall motion engine that serialises erase and draw pixels onto one VGA write stream.
// Optional build macro ENEMY_MUTUAL_COLLIDE_EN: neighbouring enemies reverse each other as if hit.
`timescale 1ns/1ps
module enemy_sprite_engine #(
  parameter int NUM_ENEMIES = 3,
  parameter int COORD_W     = 8,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 120,
  parameter int Y_START     = 60,
  parameter int TICK_DIV    = 16
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           load,
  input  logic [NUM_ENEMIES*COORD_W-1:0] spawn_x,
  input  logic [NUM_ENEMIES*3-1:0]       enemy_colour,
  input  logic [NUM_ENEMIES-1:0]         hit,
  output logic [NUM_ENEMIES*COORD_W-1:0] enemy_x,
  output logic [NUM_ENEMIES*COORD_W-1:0] enemy_y,
  output logic [COORD_W-1:0]             vga_x,
  output logic [COORD_W-1:0]             vga_y,
  output logic [2:0]                     vga_colour,
  output logic                           vga_plot,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [IDX_W-1:0]   LAST    = IDX_W'(NUM_ENEMIES - 1);
  localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(TICK_DIV - 1);
  localparam logic [COORD_W-1:0] XMAX    = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YSTART  = COORD_W'(Y_START);
  localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);
  localparam logic [COORD_W:0]   YLIM    = (COORD_W + 1)'(Y_MAX);

  typedef enum logic [1:0] {IDLE, ERASE, MOVE, DRAW} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [COORD_W-1:0]      x_q [NUM_ENEMIES];
  logic [COORD_W-1:0]      y_q [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0]  dir_q;
  logic [NUM_ENEMIES-1:0]  hit_q;
  logic [COORD_W-1:0]      vga_x_q, vga_y_q;
  logic [2:0]              vga_colour_q;
  logic                    vga_plot_q, frame_done_q;

  logic [COORD_W-1:0]      x_d [NUM_ENEMIES];
  logic [COORD_W-1:0]      y_d [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0]  dir_d;
  logic [NUM_ENEMIES-1:0]  coll;
  logic [NUM_ENEMIES-1:0]  hit_eff;
  logic                    tick;

  function automatic logic [COORD_W-1:0] spawn_col(input int i);
    logic [COORD_W-1:0] v;
    v = spawn_x[i*COORD_W +: COORD_W];
    return (v > XMAX) ? XMAX : v;
  endfunction

`ifdef ENEMY_MUTUAL_COLLIDE_EN
  always_comb begin
    logic [COORD_W-1:0] dx, dy;
    coll = '0;
    dx   = '0;
    dy   = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      for (int j = i + 1; j < NUM_ENEMIES; j++) begin
        dx = (x_q[i] >= x_q[j]) ? x_q[i] - x_q[j] : x_q[j] - x_q[i];
        dy = (y_q[i] >= y_q[j]) ? y_q[i] - y_q[j] : y_q[j] - y_q[i];
        if (dx <= ONE && dy <= ONE) begin
          coll[i] = 1'b1;
          coll[j] = 1'b1;
        end
      end
    end
  end
`else
  assign coll = '0;
`endif

  // A hit arriving in the MOVE cycle itself still counts, hence the raw port in the OR.
  assign hit_eff = hit_q | hit | coll;
  assign tick    = enable && (cnt_q == CNT_TOP);

  always_comb begin
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      x_d[i]   = x_q[i];
      y_d[i]   = y_q[i] + ONE;
      dir_d[i] = dir_q[i];
      if (({1'b0, y_q[i]} + (COORD_W + 1)'(1)) >= YLIM) begin
        x_d[i]   = spawn_col(i);
        y_d[i]   = YSTART;
        dir_d[i] = 1'b1;
      end else if (hit_eff[i]) begin
        dir_d[i] = ~dir_q[i];
        if (!dir_q[i]) x_d[i] = (x_q[i] >= XMAX) ? XMAX : x_q[i] + ONE;
        else           x_d[i] = (x_q[i] == '0) ? '0 : x_q[i] - ONE;
      end else if (dir_q[i] && x_q[i] >= XMAX) begin
        dir_d[i] = 1'b0;
        x_d[i]   = x_q[i] - ONE;
      end else if (!dir_q[i] && x_q[i] == '0) begin
        dir_d[i] = 1'b1;
        x_d[i]   = ONE;
      end else begin
        x_d[i] = dir_q[i] ? x_q[i] + ONE : x_q[i] - ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      dir_q        <= '1;
      hit_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= YSTART;
      end
    end else if (load) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      dir_q        <= '1;
      hit_q        <= '0;
      vga_plot_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        x_q[i] <= spawn_col(i);
        y_q[i] <= YSTART;
      end
    end else begin
      if (enable) cnt_q <= (cnt_q == CNT_TOP) ? '0 : cnt_q + CNT_W'(1);
      hit_q        <= hit_q | hit;
      vga_plot_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= ERASE;
            idx_q   <= '0;
          end
        end
        ERASE: begin
          vga_x_q      <= x_q[idx_q];
          vga_y_q      <= y_q[idx_q];
          vga_colour_q <= 3'd0;
          vga_plot_q   <= 1'b1;
          if (idx_q == LAST) state_q <= MOVE;
          else               idx_q   <= idx_q + IDX_W'(1);
        end
        MOVE: begin
          for (int i = 0; i < NUM_ENEMIES; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
          end
          dir_q   <= dir_d;
          hit_q   <= '0;
          state_q <= DRAW;
          idx_q   <= '0;
        end
        DRAW: begin
          vga_x_q      <= x_q[idx_q];
          vga_y_q      <= y_q[idx_q];
          vga_colour_q <= enemy_colour[idx_q*3 +: 3];
          vga_plot_q   <= 1'b1;
          if (idx_q == LAST) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    enemy_x = '0;
    enemy_y = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      enemy_x[i*COORD_W +: COORD_W] = x_q[i];
      enemy_y[i*COORD_W +: COORD_W] = y_q[i];
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule
